// File: rtl/triple_frame_buffer.sv
// Triple-buffered frame store: capture writes bank W, display reads bank D, and L holds
// the newest completed frame, so the display never shows a torn image.
module triple_frame_buffer #(
  parameter int unsigned IMG_COLS = 80,
  parameter int unsigned IMG_ROWS = 60,
  parameter int unsigned NB_ADDR  = 13,
  parameter int unsigned NB_PXL   = 16,
  parameter int unsigned NB_FCNT  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [NB_ADDR-1:0] wr_addr,
  input  logic [NB_PXL-1:0]  wr_data,
  input  logic               wr_frame_end,
  input  logic               freeze,
  input  logic               rd_frame_start,
  input  logic [NB_ADDR-1:0] rd_addr,
  output logic [NB_PXL-1:0]  rd_data,
  output logic               rd_valid,
  output logic               fresh,
  output logic [1:0]         wr_bank,
  output logic [1:0]         rd_bank,
  output logic [NB_FCNT-1:0] frame_count,
  output logic               addr_err
);

  localparam int unsigned PXLS   = IMG_COLS * IMG_ROWS;
  localparam int unsigned DEPTH  = 3 * PXLS;
  localparam int unsigned NB_RAM = $clog2(DEPTH);

  logic [NB_PXL-1:0]  mem [DEPTH];
  logic [1:0]         lt_bank;
  logic [1:0]         wr_bank_nx, rd_bank_nx, lt_bank_nx;
  logic               fresh_nx, rd_valid_nx;
  logic [NB_FCNT-1:0] frame_count_nx;
  logic               wr_evt, wr_in_range, rd_in_range, wr_ok, wr_bad;
  logic [NB_RAM-1:0]  wr_ram_addr, rd_ram_addr;

  function automatic logic [NB_RAM-1:0] ram_addr(input logic [1:0] bank,
                                                 input logic [NB_ADDR-1:0] pxl);
    return NB_RAM'(bank) * NB_RAM'(PXLS) + NB_RAM'(pxl);
  endfunction

  assign wr_evt      = wr_frame_end & ~freeze;
  assign wr_in_range = 32'(wr_addr) < PXLS;
  assign rd_in_range = 32'(rd_addr) < PXLS;
  assign wr_ok       = wr_en & ~freeze & wr_in_range;
  assign wr_bad      = wr_en & ~freeze & ~wr_in_range;
  assign wr_ram_addr = ram_addr(wr_bank, wr_addr);
  assign rd_ram_addr = ram_addr(rd_bank, rd_addr);

  // Role rotation: the capture swap is applied first, then the display swap sees its result.
  always_comb begin
    wr_bank_nx     = wr_bank;
    lt_bank_nx     = lt_bank;
    rd_bank_nx     = rd_bank;
    fresh_nx       = fresh;
    rd_valid_nx    = rd_valid;
    frame_count_nx = frame_count;
    if (wr_evt) begin
      wr_bank_nx     = lt_bank;
      lt_bank_nx     = wr_bank;
      fresh_nx       = 1'b1;
      frame_count_nx = frame_count + NB_FCNT'(1);
    end
    if (rd_frame_start && fresh_nx) begin
      rd_bank_nx  = lt_bank_nx;
      lt_bank_nx  = rd_bank;
      fresh_nx    = 1'b0;
      rd_valid_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank     <= 2'd0;
      lt_bank     <= 2'd1;
      rd_bank     <= 2'd2;
      fresh       <= 1'b0;
      rd_valid    <= 1'b0;
      frame_count <= '0;
      addr_err    <= 1'b0;
    end else begin
      wr_bank     <= wr_bank_nx;
      lt_bank     <= lt_bank_nx;
      rd_bank     <= rd_bank_nx;
      fresh       <= fresh_nx;
      rd_valid    <= rd_valid_nx;
      frame_count <= frame_count_nx;
      if (wr_bad) addr_err <= 1'b1;
    end
  end

  // Frame RAM is never cleared; only the read register is reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ram_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_in_range ? mem[rd_ram_addr] : '0;
  end

endmodule
